// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and pointer logic.
// The helpers work on a fixed maximum width. Narrower values are zero-extended
// on the way in and truncated on the way out. Both conversions are
// unaffected by leading zeros, so the result is correct for any width up to GRAY_MAXW.
package gray_pkg;

    localparam int GRAY_MAXW = 64;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray code back to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // All-ones value for a counter of the given width (the top of its range).
    function automatic logic [GRAY_MAXW-1:0] max_val(input int width);
        logic [GRAY_MAXW-1:0] m;
        m = '0;
        for (int i = 0; i < GRAY_MAXW; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational, width-parametrised Gray-to-binary converter.
// This is the inverse of the binary-to-Gray mapping. It is written as an explicit ripple
// so it stays usable at any width without the package's maximum-width limit.
module gray2bin_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // The MSB passes through. Every lower bit XORs in the binary bit above it.
    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down counter holding a binary count and its Gray image in lockstep.
// Both images are registered from the same next-state value. This lets gray_out
// serve as a clock-domain-crossing pointer with no skew relative to bin_out.
// Loads accept binary or Gray values. The range ends can wrap or saturate, and
// tc marks each update that hits a range end.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit WRAP      = 1'b1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] load_sel;
    logic [WIDTH-1:0] nxt_bin;
    logic [WIDTH-1:0] nxt_gray;
    logic             nxt_tc;
    logic             at_top;
    logic             at_bot;

    // Decode a Gray-coded load value on the side. The mux below selects it only while load is high,
    // so X on load_val cannot leak into the count while no load is in progress.
    gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
        .gray (load_val),
        .bin  (load_bin)
    );

    assign load_sel = load_gray ? load_bin : load_val;
    assign at_top   = (bin_out == MAX_VAL);
    assign at_bot   = (bin_out == '0);

    // Next-state selection: load beats count. tc flags only updates that hit a range end.
    always_comb begin
        nxt_bin = bin_out;
        nxt_tc  = 1'b0;
        if (load) begin
            nxt_bin = load_sel;
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    nxt_tc  = 1'b1;
                    nxt_bin = WRAP ? '0 : bin_out;
                end else begin
                    nxt_bin = bin_out + 1'b1;
                end
            end else begin
                if (at_bot) begin
                    nxt_tc  = 1'b1;
                    nxt_bin = WRAP ? MAX_VAL : bin_out;
                end else begin
                    nxt_bin = bin_out - 1'b1;
                end
            end
        end
    end

    // The Gray image comes from the next binary value, so both outputs update on the same edge.
    assign nxt_gray = WIDTH'(bin2gray(GRAY_MAXW'(nxt_bin)));

    // State register. The synchronous reset overrides load and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_out  <= RST_BIN;
            gray_out <= RST_GRAY;
            tc       <= 1'b0;
        end else begin
            bin_out  <= nxt_bin;
            gray_out <= nxt_gray;
            tc       <= nxt_tc;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: three instances (4-bit wrap, 4-bit saturate,
// 8-bit wrap with non-zero reset value) driven from shared stimulus.
module tb_gray_code_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load, load_gray;
    logic [7:0] load_val;

    logic [3:0] w_bin, w_gray, s_bin, s_gray;
    logic [7:0] e_bin, e_gray;
    logic       w_tc, s_tc, e_tc;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(0)) u_w4 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val[3:0]),
        .bin_out(w_bin), .gray_out(w_gray), .tc(w_tc));

    gray_code_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(0)) u_s4 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val[3:0]),
        .bin_out(s_bin), .gray_out(s_gray), .tc(s_tc));

    gray_code_counter #(.WIDTH(8), .WRAP(1'b1), .RESET_VAL(8'h80)) u_e8 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_out(e_bin), .gray_out(e_gray), .tc(e_tc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic lg, input logic [7:0] v);
        reset = r; en = e; up_dn = u; load = l; load_gray = lg; load_val = v;
        @(posedge clk);
        #1;
    endtask

    // The bench's own Gray decode, written as a shift-XOR sum.
    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) b = b ^ (g >> k);
        return b;
    endfunction

    logic [3:0] gseq [0:16];
    logic [3:0] prev_gray;
    logic [7:0] m_bin;
    logic       m_tc;

    initial begin
        gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD,
                 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_gray = 1'b0; load_val = 8'hFF;
        @(negedge clk);

        // Reset held two cycles while load and en are also asserted.
        drive(1, 1, 1, 1, 0, 8'hFF);
        drive(1, 1, 1, 1, 0, 8'hFF);
        chk("rst_w4_bin", 32'(w_bin), 32'h0);
        chk("rst_w4_gray", 32'(w_gray), 32'h0);
        chk("rst_w4_tc", 32'(w_tc), 32'h0);
        chk("rst_s4_bin", 32'(s_bin), 32'h0);
        chk("rst_e8_bin", 32'(e_bin), 32'h80);
        chk("rst_e8_gray", 32'(e_gray), 32'hC0);
        chk("rst_e8_tc", 32'(e_tc), 32'h0);

        // 17 up-counts from 0 through the wrap. X on load_val must be ignored.
        prev_gray = w_gray;
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 1, 0, 0, 8'hxx);
            chk("up_gray", 32'(w_gray), 32'(gseq[i]));
            chk("up_bin", 32'(w_bin), 32'((i + 1) % 16));
            chk("up_tc", 32'(w_tc), (i == 15) ? 32'h1 : 32'h0);
            chk("up_onebit", $countones(prev_gray ^ w_gray), 32'h1);
            prev_gray = w_gray;
        end
        chk("sat_top_bin", 32'(s_bin), 32'hF);
        chk("sat_top_tc", 32'(s_tc), 32'h1);

        // Loads.
        drive(0, 0, 1, 1, 0, 8'h0B);
        chk("ld_bin", 32'(w_bin), 32'hB);
        chk("ld_gray", 32'(w_gray), 32'hE);
        chk("ld_tc", 32'(w_tc), 32'h0);
        chk("ld_e8_gray", 32'(e_gray), 32'h0E);
        drive(0, 0, 1, 1, 1, 8'h05);
        chk("ldg_bin", 32'(w_bin), 32'h6);
        chk("ldg_gray", 32'(w_gray), 32'h5);
        drive(0, 1, 1, 1, 0, 8'h03);
        chk("ld_over_en", 32'(w_bin), 32'h3);

        // Down from 0: wrap versus saturate.
        drive(0, 0, 0, 1, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("dn_w_bin", 32'(w_bin), 32'hF);
        chk("dn_w_gray", 32'(w_gray), 32'h8);
        chk("dn_w_tc", 32'(w_tc), 32'h1);
        chk("dn_s_bin", 32'(s_bin), 32'h0);
        chk("dn_s_tc", 32'(s_tc), 32'h1);
        chk("dn_s_gray", 32'(s_gray), 32'h0);
        drive(0, 1, 0, 0, 0, 8'h00);
        chk("dn2_w_bin", 32'(w_bin), 32'hE);
        chk("dn2_w_tc", 32'(w_tc), 32'h0);
        chk("dn2_s_bin", 32'(s_bin), 32'h0);
        chk("dn2_s_tc", 32'(s_tc), 32'h1);
        drive(0, 1, 1, 0, 0, 8'h00);
        chk("turn_s_bin", 32'(s_bin), 32'h1);
        chk("turn_s_tc", 32'(s_tc), 32'h0);
        chk("turn_w_bin", 32'(w_bin), 32'hF);

        // Idle: hold value, tc low.
        drive(0, 0, 1, 0, 0, 8'h00);
        chk("hold_bin", 32'(w_bin), 32'hF);
        chk("hold_tc", 32'(w_tc), 32'h0);

        // Reset in the middle of a count.
        drive(0, 0, 1, 1, 0, 8'h09);
        chk("pre_rst_bin", 32'(w_bin), 32'h9);
        drive(1, 1, 1, 0, 0, 8'h00);
        chk("mid_rst_bin", 32'(w_bin), 32'h0);
        chk("mid_rst_tc", 32'(w_tc), 32'h0);
        chk("mid_rst_e8", 32'(e_bin), 32'h80);
        drive(0, 1, 1, 0, 0, 8'h00);
        chk("resume_bin", 32'(w_bin), 32'h1);
        chk("resume_e8", 32'(e_bin), 32'h81);

        // Random traffic on the 8-bit instance against a scoreboard model.
        m_bin = e_bin == 8'h81 ? 8'h81 : 8'h81;
        for (int i = 0; i < 200; i++) begin
            logic r_en, r_up, r_ld, r_lg;
            logic [7:0] r_v;
            r_en = 1'($urandom);
            r_up = 1'($urandom);
            r_ld = ($urandom_range(0, 7) == 0);
            r_lg = 1'($urandom);
            r_v  = 8'($urandom);
            if (i % 50 == 10) begin
                r_v = 8'hFE; r_ld = 1'b1; r_lg = 1'b0;
            end
            m_tc = 1'b0;
            if (r_ld) m_bin = r_lg ? g2b8(r_v) : r_v;
            else if (r_en) begin
                if (r_up) begin m_tc = (m_bin == 8'hFF); m_bin = m_bin + 8'd1; end
                else      begin m_tc = (m_bin == 8'h00); m_bin = m_bin - 8'd1; end
            end
            drive(0, r_en, r_up, r_ld, r_lg, r_v);
            chk("rnd_bin", 32'(e_bin), 32'(m_bin));
            chk("rnd_tc", 32'(e_tc), 32'(m_tc));
            chk("rnd_inv8", 32'(e_gray), 32'(e_bin ^ (e_bin >> 1)));
            chk("rnd_inv_w4", 32'(w_gray), 32'(w_bin ^ (w_bin >> 1)));
            chk("rnd_inv_s4", 32'(s_gray), 32'(s_bin ^ (s_bin >> 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
